// File: rtl/aes_inv_cipher_top.sv
// AES-128 inverse cipher with iterative datapath and optional round-key cache.
//   AES_clk            in   1    clock, rising edge
//   AES_rst            in   1    synchronous active-high reset
//   AES_en             in   1    start request, honoured only when idle
//   AES_data_in        in   128  ciphertext, byte 0 in [127:120]
//   AES_key_in         in   128  cipher key, byte 0 in [127:120]
//   AES_data_out       out  128  plaintext
//   AES_data_out_valid out  1    plaintext valid (pulse, or held when VALID_HOLD=1)
//   AES_busy           out  1    key expansion or decryption in progress

package aes_inv_cipher_pkg;

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] a;
        p = '0;
        a = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ a;
            a = xtime(a);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0 as AES requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x3, x7, x15, x31, x63, x127;
        x3   = gf_mul(gf_mul(x, x), x);
        x7   = gf_mul(gf_mul(x3, x3), x);
        x15  = gf_mul(gf_mul(x7, x7), x);
        x31  = gf_mul(gf_mul(x15, x15), x);
        x63  = gf_mul(gf_mul(x31, x31), x);
        x127 = gf_mul(gf_mul(x63, x63), x);
        return gf_mul(x127, x127);
    endfunction

    // InvMixColumns on one column; a[31:24] is row 0.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
        logic [7:0] b [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            b[i]  = a[31-8*i -: 8];
            x2    = xtime(b[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ b[i];
            mb[i] = x8 ^ x2 ^ b[i];
            md[i] = x8 ^ x4 ^ b[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

endpackage

// Forward S-box: GF inverse followed by the affine transform.
//   a in 8, y out 8
module aes_sbox
    import aes_inv_cipher_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);
    logic [7:0] inv;

    assign inv = gf_inv(a);
    assign y   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

// Inverse S-box: inverse affine transform followed by the GF inverse.
//   a in 8, y out 8
module aes_inv_sbox
    import aes_inv_cipher_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);
    logic [7:0] t;

    assign t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    assign y = gf_inv(t);
endmodule

// Top level: expand the key forward into rk[0..10], then run the inverse rounds.
module aes_inv_cipher_top
    import aes_inv_cipher_pkg::*;
#(
    parameter int unsigned AES_NR     = 10,
    parameter int unsigned KEY_CACHE  = 1,
    parameter int unsigned VALID_HOLD = 0
) (
    input  logic         AES_clk,
    input  logic         AES_rst,
    input  logic         AES_en,
    input  logic [127:0] AES_data_in,
    input  logic [127:0] AES_key_in,
    output logic [127:0] AES_data_out,
    output logic         AES_data_out_valid,
    output logic         AES_busy
);
    localparam int unsigned NR       = AES_NR;
    localparam logic [3:0]  CTR_LAST = 4'(NR);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_KEXP = 2'd1;
    localparam logic [1:0] S_DEC  = 2'd2;

    logic [1:0]   fsm, fsm_nxt;
    logic [3:0]   ctr;
    logic [127:0] st;
    logic [127:0] rk [0:NR];
    logic [127:0] cache_key;
    logic         cache_vld;

    logic         hit_c;
    logic [3:0]   kidx;
    logic [127:0] rk_prev, rk_cur, rk_new;
    logic [31:0]  rot_w, sub_w, temp_w;
    logic [31:0]  n0, n1, n2, n3;
    logic [7:0]   rcon;
    logic [127:0] isr, isb, ark, imc;

    assign hit_c = (KEY_CACHE != 0) && cache_vld && (AES_key_in == cache_key);

    // Key expansion step from the previous round key.
    assign kidx    = (ctr == 4'd0) ? 4'd0 : ctr - 4'd1;
    assign rk_prev = rk[kidx];
    assign rk_cur  = rk[ctr];
    assign rot_w   = {rk_prev[23:0], rk_prev[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_ksbox
        aes_sbox u_sbox (
            .a(rot_w[31-8*i -: 8]),
            .y(sub_w[31-8*i -: 8])
        );
    end

    always_comb begin
        rcon = 8'h00;
        case (ctr)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign temp_w = sub_w ^ {rcon, 24'h000000};
    assign n0     = rk_prev[127:96] ^ temp_w;
    assign n1     = rk_prev[95:64] ^ n0;
    assign n2     = rk_prev[63:32] ^ n1;
    assign n3     = rk_prev[31:0] ^ n2;
    assign rk_new = {n0, n1, n2, n3};

    // Inverse round: InvShiftRows (row r rotates right by r) then InvSubBytes.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int unsigned DST = 4*c + r;
            localparam int unsigned SRC = 4*((c + 4 - r) % 4) + r;
            assign isr[127-8*DST -: 8] = st[127-8*SRC -: 8];
            aes_inv_sbox u_isbox (
                .a(isr[127-8*DST -: 8]),
                .y(isb[127-8*DST -: 8])
            );
        end
        assign imc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
    end

    assign ark = isb ^ rk_cur;

    // FSM state register.
    always_ff @(posedge AES_clk) begin
        if (AES_rst) fsm <= S_IDLE;
        else         fsm <= fsm_nxt;
    end

    // Next-state logic.
    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            S_IDLE:  if (AES_en) fsm_nxt = hit_c ? S_DEC : S_KEXP;
            S_KEXP:  if (ctr == CTR_LAST) fsm_nxt = S_DEC;
            S_DEC:   if (ctr == 4'd0) fsm_nxt = S_IDLE;
            default: fsm_nxt = S_IDLE;
        endcase
    end

    // Datapath, counter, cache bookkeeping and registered outputs.
    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            ctr                <= 4'd0;
            st                 <= '0;
            cache_key          <= '0;
            cache_vld          <= 1'b0;
            AES_data_out       <= '0;
            AES_data_out_valid <= 1'b0;
            AES_busy           <= 1'b0;
        end else begin
            if (VALID_HOLD == 0) AES_data_out_valid <= 1'b0;
            case (fsm)
                S_IDLE: begin
                    if (AES_en) begin
                        AES_busy           <= 1'b1;
                        AES_data_out_valid <= 1'b0;
                        if (hit_c) begin
                            st  <= AES_data_in ^ rk[CTR_LAST];
                            ctr <= CTR_LAST - 4'd1;
                        end else begin
                            // rk file is about to be rewritten; not reusable until done.
                            st        <= AES_data_in;
                            cache_key <= AES_key_in;
                            cache_vld <= 1'b0;
                            ctr       <= 4'd1;
                        end
                    end
                end
                S_KEXP: begin
                    if (ctr == CTR_LAST) begin
                        st        <= st ^ rk_new;
                        cache_vld <= 1'b1;
                        ctr       <= CTR_LAST - 4'd1;
                    end else begin
                        ctr <= ctr + 4'd1;
                    end
                end
                S_DEC: begin
                    if (ctr == 4'd0) begin
                        AES_data_out       <= ark;
                        AES_data_out_valid <= 1'b1;
                        AES_busy           <= 1'b0;
                    end else begin
                        st  <= imc;
                        ctr <= ctr - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Round-key file; contents only trusted while cache_vld is set.
    always_ff @(posedge AES_clk) begin
        if (fsm == S_IDLE && AES_en && !hit_c) rk[0] <= AES_key_in;
        else if (fsm == S_KEXP)                rk[ctr] <= rk_new;
    end

endmodule

// File: tb/tb_aes_inv_cipher_top.sv
// Bench for aes_inv_cipher_top: known-answer vectors, cache/latency, reset abort,
// busy-time requests, random round trips against an encryption model, held valid.
module tb_aes_inv_cipher_top;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
        int           lat;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst, en, en_h;
    logic [127:0] data_in, key_in;
    logic [127:0] data_out, data_h;
    logic         valid, busy, valid_h, busy_h;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_inv_cipher_top #(.AES_NR(10), .KEY_CACHE(1), .VALID_HOLD(0)) u_dut (
        .AES_clk(clk), .AES_rst(rst), .AES_en(en),
        .AES_data_in(data_in), .AES_key_in(key_in),
        .AES_data_out(data_out), .AES_data_out_valid(valid), .AES_busy(busy)
    );

    aes_inv_cipher_top #(.AES_NR(10), .KEY_CACHE(1), .VALID_HOLD(1)) u_hold (
        .AES_clk(clk), .AES_rst(rst), .AES_en(en_h),
        .AES_data_in(data_in), .AES_key_in(key_in),
        .AES_data_out(data_h), .AES_data_out_valid(valid_h), .AES_busy(busy_h)
    );

    // ---------------- reference encryption model ----------------
    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [2047:0] t;
        t = SBOX;
        return t[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mixcol(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        a0 = a[31:24]; a1 = a[23:16]; a2 = a[15:8]; a3 = a[7:0];
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [127:0] rk, s, t;
        logic [31:0]  w;
        logic [7:0]   rc;
        rk = key;
        s  = pt ^ rk;
        rc = 8'h01;
        for (int rnd = 1; rnd <= 10; rnd++) begin
            w = {rk[23:0], rk[31:24]};
            w = {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])} ^ {rc, 24'h000000};
            rk[127:96] = rk[127:96] ^ w;
            rk[95:64]  = rk[95:64] ^ rk[127:96];
            rk[63:32]  = rk[63:32] ^ rk[95:64];
            rk[31:0]   = rk[31:0] ^ rk[63:32];
            rc = xt(rc);
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[127 - 8*(4*c + r) -: 8] = sb(s[127 - 8*(4*((c + r) % 4) + r) -: 8]);
            if (rnd != 10)
                for (int c = 0; c < 4; c++)
                    t[127 - 32*c -: 32] = mixcol(t[127 - 32*c -: 32]);
            s = t ^ rk;
        end
        return s;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Issue one request on u_dut and wait for its result; returns in the valid cycle.
    task automatic run_op(input logic [127:0] k, input logic [127:0] ct,
                          input logic [127:0] pt, input int lat, input string name);
        int n;
        key_in  = k;
        data_in = ct;
        en      = 1'b1;
        tick();
        en      = 1'b0;
        data_in = rnd128();
        key_in  = rnd128();
        check({name, " busy_after_capture"}, 128'(busy), 128'(1));
        check({name, " valid_after_capture"}, 128'(valid), 128'(0));
        n = 0;
        while (!valid && n < 40) begin
            tick();
            n++;
        end
        check({name, " latency"}, 128'(n), 128'(lat));
        check({name, " plaintext"}, data_out, pt);
        check({name, " busy_at_valid"}, 128'(busy), 128'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs[8];
        logic [127:0] k, pt, got, last_key;
        int           n, vcount, first, lat;

        vecs[0] = '{C1_KEY, C1_CT, C1_PT, 20};
        vecs[1] = '{B_KEY,  B_CT,  B_PT,  20};
        vecs[2] = '{B_KEY,  B_CT,  B_PT,  10};
        vecs[3] = '{C1_KEY, C1_CT, C1_PT, 20};
        vecs[4] = '{C1_KEY, C1_CT, C1_PT, 10};
        vecs[5] = '{'0,     Z_CT,  '0,    20};
        vecs[6] = '{'0,     Z_CT,  '0,    10};
        vecs[7] = '{B_KEY,  B_CT,  B_PT,  20};

        rst = 1'b1; en = 1'b0; en_h = 1'b0; data_in = '0; key_in = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset data_out", data_out, '0);
        check("reset valid", 128'(valid), 128'(0));
        check("reset busy", 128'(busy), 128'(0));
        check("reset hold valid", 128'(valid_h), 128'(0));

        // Known answers, issued back-to-back in the valid cycle.
        for (int i = 0; i < 8; i++)
            run_op(vecs[i].key, vecs[i].ct, vecs[i].pt, vecs[i].lat, $sformatf("vec%0d", i));
        tick();
        check("pulse drop", 128'(valid), 128'(0));

        // Reset seven cycles into a miss run; cache must be invalidated.
        key_in = C1_KEY; data_in = C1_CT; en = 1'b1;
        tick();
        en = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort data_out", data_out, '0);
        check("abort valid", 128'(valid), 128'(0));
        check("abort busy", 128'(busy), 128'(0));
        run_op(C1_KEY, C1_CT, C1_PT, 20, "rerun_after_abort");
        tick();

        // Requests with garbage while busy must be ignored.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        key_in = C1_KEY; data_in = C1_CT; en = 1'b1;
        tick();
        en = 1'b0;
        vcount = 0; first = -1; got = '0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 3 || c == 15) begin
                en = 1'b1; data_in = rnd128(); key_in = rnd128();
            end else begin
                en = 1'b0;
            end
            tick();
            if (valid) begin
                vcount++;
                if (vcount == 1) begin
                    first = c;
                    got   = data_out;
                end
            end
        end
        en = 1'b0;
        check("busy_en latency", 128'(first), 128'(20));
        check("busy_en plaintext", got, C1_PT);
        check("busy_en valid count", 128'(vcount), 128'(1));

        // Random round trips; bench tracks which keys should hit the cache.
        last_key = C1_KEY;
        k = '0;
        for (int i = 0; i < 200; i++) begin
            if (i % 3 == 0) k = rnd128();
            pt  = rnd128();
            lat = (k == last_key) ? 10 : 20;
            run_op(k, aes_enc(k, pt), pt, lat, $sformatf("rt%0d", i));
            last_key = k;
        end
        tick();

        // Held-valid instance.
        key_in = C1_KEY; data_in = C1_CT; en_h = 1'b1;
        tick();
        en_h = 1'b0;
        n = 0;
        while (!valid_h && n < 40) begin
            tick();
            n++;
        end
        check("hold latency", 128'(n), 128'(20));
        check("hold plaintext", data_h, C1_PT);
        repeat (5) tick();
        check("hold valid kept", 128'(valid_h), 128'(1));
        check("hold data kept", data_h, C1_PT);
        key_in = B_KEY; data_in = B_CT; en_h = 1'b1;
        tick();
        en_h = 1'b0;
        check("hold valid drop at capture", 128'(valid_h), 128'(0));
        n = 0;
        while (!valid_h && n < 40) begin
            tick();
            n++;
        end
        check("hold second latency", 128'(n), 128'(20));
        check("hold second plaintext", data_h, B_PT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
